// File: rtl/float16_divider.sv
// rtl/float16_divider.sv - iterative IEEE 754 half-precision divider, result = a / b
module float16_divider #(
    parameter int LATENCY = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ITER   = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    // Accept and UNPACK take one edge each, ROUND lands on edge LATENCY.
    localparam int          ITER_CYCLES = LATENCY - 2;
    localparam logic [3:0]  ITER_LAST   = 4'(ITER_CYCLES - 1);

    logic [2:0]         state;
    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic               sign;
    logic signed [6:0]  exp_q;
    logic [11:0]        rem;
    logic [10:0]        div;
    logic [12:0]        quo;
    logic [3:0]         cnt;
    logic               special;
    logic [15:0]        special_res;
    logic [15:0]        result_q;

    // Operand classification; exp=0 is treated as zero, so subnormals flush.
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        u_sign;
    logic [10:0] ma, mb;
    logic signed [6:0] e0;

    always_comb begin
        a_zero = (a_q[14:10] == 5'd0);
        b_zero = (b_q[14:10] == 5'd0);
        a_inf  = (a_q[14:10] == 5'd31) && (a_q[9:0] == 10'd0);
        b_inf  = (b_q[14:10] == 5'd31) && (b_q[9:0] == 10'd0);
        a_nan  = (a_q[14:10] == 5'd31) && (a_q[9:0] != 10'd0);
        b_nan  = (b_q[14:10] == 5'd31) && (b_q[9:0] != 10'd0);
        u_sign = a_q[15] ^ b_q[15];
        ma     = {1'b1, a_q[9:0]};
        mb     = {1'b1, b_q[9:0]};
        e0     = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]}) + 7'sd15;
    end

    logic [11:0] rem_next;
    logic        q_bit;

    always_comb begin
        q_bit    = (rem >= {1'b0, div});
        rem_next = q_bit ? (rem - {1'b0, div}) : rem;
    end

    // Round-to-nearest-even on quo = {int, frac[9:0], G, R}, sticky from remainder.
    logic              inc;
    logic [11:0]       mant_sum;
    logic              carry;
    logic signed [6:0] exp_r;
    logic [15:0]       normal_res;

    always_comb begin
        inc        = quo[1] && (quo[0] || (rem != 12'd0) || quo[2]);
        mant_sum   = {1'b0, quo[12:2]} + {11'd0, inc};
        carry      = (mant_sum[11:10] == 2'b10);
        exp_r      = carry ? (exp_q + 7'sd1) : exp_q;
        if (exp_r >= 7'sd31)
            normal_res = {sign, 15'h7C00};
        else if (exp_r <= 7'sd0)
            normal_res = {sign, 15'h0000};
        else
            normal_res = {sign, exp_r[4:0], carry ? 10'd0 : mant_sum[9:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            sign        <= 1'b0;
            exp_q       <= 7'sd0;
            rem         <= 12'd0;
            div         <= 11'd0;
            quo         <= 13'd0;
            cnt         <= 4'd0;
            special     <= 1'b0;
            special_res <= 16'd0;
            result_q    <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign <= u_sign;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        special     <= 1'b1;
                        special_res <= 16'h7E00;
                    end else if (a_inf || b_zero) begin
                        special     <= 1'b1;
                        special_res <= {u_sign, 15'h7C00};
                    end else if (a_zero || b_inf) begin
                        special     <= 1'b1;
                        special_res <= {u_sign, 15'h0000};
                    end else begin
                        special     <= 1'b0;
                        special_res <= 16'd0;
                    end
                    // Pre-normalise so the quotient falls in [1, 2).
                    if (ma < mb) begin
                        rem   <= {ma, 1'b0};
                        exp_q <= e0 - 7'sd1;
                    end else begin
                        rem   <= {1'b0, ma};
                        exp_q <= e0;
                    end
                    div   <= mb;
                    quo   <= 13'd0;
                    cnt   <= 4'd0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    quo <= {quo[11:0], q_bit};
                    rem <= {rem_next[10:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == ITER_LAST)
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    result_q <= special ? special_res : normal_res;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_float16_divider.sv
// tb/tb_float16_divider.sv - self-checking bench for float16_divider
module tb_float16_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    float16_divider #(.LATENCY(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Exact quotient computed with integer division, rounded to nearest even.
    function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
        logic s;
        int ex, ey, fx, fy, mx, my, e, q, r;
        logic xz, yz, xi, yi, xn, yn;
        logic [6:0] e_bits;
        logic [10:0] q_bits;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        fx = int'(x[9:0]);   fy = int'(y[9:0]);
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 31) && (fx == 0); yi = (ey == 31) && (fy == 0);
        xn = (ex == 31) && (fx != 0); yn = (ey == 31) && (fy != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return 16'h7E00;
        if (xi || yz) return {s, 15'h7C00};
        if (xz || yi) return {s, 15'h0000};
        mx = 1024 + fx;
        my = 1024 + fy;
        e  = ex - ey + 15;
        if (mx < my) begin
            mx = mx * 2;
            e  = e - 1;
        end
        q = (mx * 1024) / my;
        r = (mx * 1024) % my;
        if ((2 * r > my) || ((2 * r == my) && (q % 2 == 1))) q = q + 1;
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        e_bits = 7'(e);
        q_bits = 11'(q);
        return {s, e_bits[4:0], q_bits[9:0]};
    endfunction

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check16("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic wait_result(output int lat);
        logic busy_ok;
        busy_ok = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check16("busy_during_op", {15'd0, busy_ok}, 16'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check16("in_ready_after_hs", {15'd0, in_ready}, 16'd1);
        check16("out_valid_after_hs", {15'd0, out_valid}, 16'd0);
    endtask

    task automatic do_div(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp);
        int lat;
        start_op(x, y);
        wait_result(lat);
        check16({tag, "_latency"}, 16'(lat), 16'd15);
        check16(tag, result, exp);
        handshake();
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] q;
    } vec_t;

    initial begin
        vec_t dir[$];
        int lat;
        logic [15:0] x, y;

        // Reset state while rst_n is low.
        #12;
        check16("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check16("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check16("rst_busy", {15'd0, busy}, 16'd0);
        check16("rst_result", result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        dir.push_back('{16'h4600, 16'h4000, 16'h4200});
        dir.push_back('{16'h3C00, 16'h4200, 16'h3555});
        dir.push_back('{16'hC000, 16'h3800, 16'hC400});
        dir.push_back('{16'h3C00, 16'h3C00, 16'h3C00});
        dir.push_back('{16'h3C00, 16'h0000, 16'h7C00});
        dir.push_back('{16'h0000, 16'h0000, 16'h7E00});
        dir.push_back('{16'h7E00, 16'h3C00, 16'h7E00});
        dir.push_back('{16'h7C00, 16'h7C00, 16'h7E00});
        dir.push_back('{16'hBC00, 16'h7C00, 16'h8000});
        dir.push_back('{16'h0001, 16'h3C00, 16'h0000});
        dir.push_back('{16'h7BFF, 16'h3800, 16'h7C00});
        dir.push_back('{16'h0400, 16'h4000, 16'h0000});
        foreach (dir[i]) begin
            do_div($sformatf("dir%0d_%h_%h", i, dir[i].x, dir[i].y), dir[i].x, dir[i].y, dir[i].q);
        end

        // Random operands; half with exponents kept mid-range so the normal path dominates.
        for (int i = 0; i < 60; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 2 == 0) begin
                x[14:10] = 5'($urandom_range(8, 22));
                y[14:10] = 5'($urandom_range(8, 22));
            end
            do_div($sformatf("rnd%0d_%h_%h", i, x, y), x, y, ref_div(x, y));
        end

        // Backpressure: result held, in_ready low, stray in_valid ignored.
        start_op(16'h3C00, 16'h4200);
        wait_result(lat);
        check16("bp_latency", 16'(lat), 16'd15);
        check16("bp_result", result, 16'h3555);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a = 16'h4600;
                b = 16'h4000;
                in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk); #1;
            check16($sformatf("bp_hold_result%0d", i), result, 16'h3555);
            check16($sformatf("bp_hold_in_ready%0d", i), {15'd0, in_ready}, 16'd0);
            check16($sformatf("bp_hold_out_valid%0d", i), {15'd0, out_valid}, 16'd1);
        end
        handshake();
        check16("bp_busy_after_hs", {15'd0, busy}, 16'd0);
        @(posedge clk); #1;
        check16("bp_stray_ignored", {15'd0, busy}, 16'd0);
        do_div("bp_next", 16'h4600, 16'h4000, 16'h4200);

        // Asynchronous reset in the middle of a division.
        start_op(16'h3C00, 16'h4200);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check16("arst_out_valid", {15'd0, out_valid}, 16'd0);
        check16("arst_result", result, 16'h0000);
        check16("arst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check16("arst_in_ready", {15'd0, in_ready}, 16'd1);
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) break;
        end
        check16("arst_no_stale", {15'd0, out_valid}, 16'd0);
        do_div("arst_next", 16'h4600, 16'h4000, 16'h4200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float16_divider.md
Name: float16_divider

Overview:
- Iterative IEEE 754 half-precision divider: result = a / b.
- Inverse operation of the team's combinational float16_multiplication block.
- Sits beside the multiplier in the float16 arithmetic unit.
- Restoring radix-2 mantissa division with a valid/ready handshake on both sides; one division in flight at a time.

Parameters:
- LATENCY, 15, fixed cycles from input accept to out_valid. Applies to all operand classes. Not overridable in practice; exposed for benches only.

Ports:
- clk        input   1   rising-edge clock
- rst_n      input   1   asynchronous active-low reset
- in_valid   input   1   operands a, b valid
- in_ready   output  1   divider idle, can accept operands
- a          input   16  dividend, float16
- b          input   16  divisor, float16
- out_valid  output  1   result valid
- out_ready  input   1   consumer accepts result
- result     output  16  quotient, float16
- busy       output  1   high from accept until result handshake completes

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n is low: in_ready=1, out_valid=0, busy=0, result=16'h0000, FSM=IDLE. Asserting rst_n mid-operation aborts the division; no stale result ever appears.
- FSM states:
  - IDLE: in_ready=1. Accepts a, b on in_valid&&in_ready, then moves to UNPACK.
  - UNPACK: 1 cycle. Classifies operands, computes sign and exponent, pre-normalises mantissas.
  - ITER: 13 cycles, one quotient bit per cycle.
  - ROUND: 1 cycle. Rounds, then checks for overflow and underflow.
  - HOLD: out_valid=1. Moves to IDLE on out_valid&&out_ready.
- Accept edge counts as edge 0. out_valid rises after edge 15 (LATENCY).
- result is stable while out_valid=1.
- in_ready rises again in the cycle after the output handshake. The block never accepts new operands on the same edge as the output handshake.
- in_valid is ignored while the FSM is not in IDLE.
- Subnormals: any input with exp=0 is treated as signed zero. Outputs never contain subnormals (flush to zero).
- Sign: s = sa ^ sb for all non-NaN results.
- Special cases (resolved in UNPACK; normal latency still applies):
  - Any NaN input, 0/0, or inf/inf gives canonical NaN 16'h7E00.
  - inf/finite, or nonzero/0, gives {s, 16'h7C00[14:0]}, i.e. signed infinity.
  - 0/nonzero, or finite/inf, gives signed zero {s, 15'h0}.
- Normal path:
  - Mantissas: ma = {1, fa}, mb = {1, fb}.
  - Exponent: e = ea - eb + 15, held as signed 7-bit.
  - If ma < mb: shift ma left 1 and set e = e - 1, so the quotient lies in [1, 2).
  - Restoring division produces 13 bits: 1 integer bit, 10 fraction bits, guard G, round R.
  - Sticky S = (final remainder != 0).
- Rounding: round-to-nearest-even. Increment when G && (R || S || lsb).
  - If the increment carries out of the mantissa: mantissa becomes 0 and e = e + 1.
- Range checks after rounding:
  - e >= 31 gives signed infinity.
  - e <= 0 gives signed zero.

Test Plan:
- 16'h4600 / 16'h4000 (6.0/2.0) -> result 16'h4200 (3.0). out_valid exactly 15 cycles after accept. busy high throughout.
- 16'h3C00/16'h4200 -> 16'h3555. 16'hC000/16'h3800 -> 16'hC400. 16'h3C00/16'h3C00 -> 16'h3C00.
- Special cases:
  - 16'h3C00/16'h0000 -> 16'h7C00.
  - 16'h0000/16'h0000 -> 16'h7E00.
  - 16'h7E00/16'h3C00 -> 16'h7E00.
  - 16'h7C00/16'h7C00 -> 16'h7E00.
  - 16'hBC00/16'h7C00 -> 16'h8000.
  - 16'h0001/16'h3C00 -> 16'h0000.
- Range: 16'h7BFF/16'h3800 -> 16'h7C00 (overflow). 16'h0400/16'h4000 -> 16'h0000 (flush).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: result constant, in_ready=0, and a second in_valid pulse during that window is ignored. After the handshake, in_ready=1 on the next cycle and a new operand pair is accepted.
- Reset mid-op: drop rst_n at cycle 7 of a division. Required: out_valid=0 and result=16'h0000 immediately (asynchronous), in_ready=1 after release. The next division, 16'h4600/16'h4000, returns 16'h4200.
